// File: rtl/reorder_buffer_pkg.sv
// ---------------------------------------------------------------------------
// operationList: types and constants shared by the reorder buffer and the
// code around it.
//   ROB_DEPTH    default number of reorder-buffer entries (power of two)
//   ROB_IDX_W    width of an entry index for the default depth
//   PREG_W       width of a physical register number (0 means "no register")
//   NUM_CMP      number of completion reporting ports (one per functional unit)
//   rob_state_t  RUN   - accepting dispatch
//                DRAIN - fetch finished, retiring what is left
//                DONE  - everything retired, sticky until reset
//   rob_entry_t  per-entry payload: new and previous physical destination
// ---------------------------------------------------------------------------
package operationList;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
    localparam int PREG_W    = 6;
    localparam int NUM_CMP   = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } rob_state_t;

    typedef struct packed {
        logic [PREG_W-1:0] p_rd;
        logic [PREG_W-1:0] p_old_rd;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer: two-wide in-order retirement buffer.
//
// Dispatch (up to two per cycle) allocates entries at the tail, functional
// units mark entries done through NUM_CMP completion ports, and up to two
// done entries retire per cycle from the head, releasing the previous
// physical destination of each retired instruction back to the free list.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   disp_valid1/2             dispatch requests (lane 2 only counts with lane 1)
//   disp_p_rd1/2              new physical destination of each lane
//   disp_p_old_rd1/2          previous physical destination of each lane
//   disp_ready                at least two entries free and state is RUN
//   rob_idx1/2                entry indices handed to lanes 1/2 this cycle
//   cmp_valid[k], cmp_idx[k]  completion report from functional unit k
//   finish_fetch              fetch has delivered its last instruction
//   free_reg1/2               registers released this cycle (0 = none)
//   retire_valid1/2           an entry retired on that lane this cycle
//   count, empty, full        occupancy
//   finish                    all work retired after fetch finished
// ---------------------------------------------------------------------------
module reorder_buffer
    import operationList::*;
#(
    parameter int  DEPTH = ROB_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              disp_valid1,
    input  logic              disp_valid2,
    input  logic [PREG_W-1:0] disp_p_rd1,
    input  logic [PREG_W-1:0] disp_p_old_rd1,
    input  logic [PREG_W-1:0] disp_p_rd2,
    input  logic [PREG_W-1:0] disp_p_old_rd2,
    output logic              disp_ready,
    output logic [IDX_W-1:0]  rob_idx1,
    output logic [IDX_W-1:0]  rob_idx2,

    input  logic              cmp_valid [0:NUM_CMP-1],
    input  logic [IDX_W-1:0]  cmp_idx   [0:NUM_CMP-1],

    input  logic              finish_fetch,

    output logic [PREG_W-1:0] free_reg1,
    output logic [PREG_W-1:0] free_reg2,
    output logic              retire_valid1,
    output logic              retire_valid2,

    output logic [IDX_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              finish
);

    // Pointers carry one extra wrap bit so that tail - head is the occupancy
    // even when both indices are equal (empty versus full).
    logic [IDX_W:0]   head_reg;
    logic [IDX_W:0]   tail_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] done_reg;
    rob_state_t       state_reg;
    rob_state_t       state_next;

    // Entry payload; reads are combinational because the retiring entry's
    // old register must appear on free_reg in the same cycle.
    rob_entry_t entry_mem [DEPTH];

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] head1_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] tail1_idx;

    logic             disp_we1;
    logic             disp_we2;
    logic             ret1;
    logic             ret2;
    logic [1:0]       disp_n;
    logic [1:0]       ret_n;
    logic [IDX_W:0]   count_next;

    logic [DEPTH-1:0] disp_hit;
    logic [DEPTH-1:0] ret_hit;
    logic [DEPTH-1:0] cmp_hit;
    logic [DEPTH-1:0][NUM_CMP-1:0] cmp_match;

    assign head_idx  = head_reg[IDX_W-1:0];
    assign head1_idx = head_idx + 1'b1;
    assign tail_idx  = tail_reg[IDX_W-1:0];
    assign tail1_idx = tail_idx + 1'b1;

    // Occupancy is the registered pointer distance, so disp_ready never sees
    // a same-cycle retirement.
    assign count      = tail_reg - head_reg;
    assign empty      = (count == '0);
    assign full       = (count == (IDX_W+1)'(DEPTH));
    assign disp_ready = (state_reg == RUN) && (count <= (IDX_W+1)'(DEPTH - 2));
    assign finish     = (state_reg == DONE);

    assign rob_idx1 = tail_idx;
    assign rob_idx2 = tail1_idx;

    assign disp_we1 = disp_valid1 && disp_ready;
    assign disp_we2 = disp_we1 && disp_valid2;

    // Retirement looks only at registered done bits; a completion arriving
    // this cycle becomes eligible on the next one.
    assign ret1 = valid_reg[head_idx] && done_reg[head_idx];
    assign ret2 = ret1 && valid_reg[head1_idx] && done_reg[head1_idx];

    assign retire_valid1 = ret1;
    assign retire_valid2 = ret2;
    assign free_reg1     = ret1 ? entry_mem[head_idx].p_old_rd  : '0;
    assign free_reg2     = ret2 ? entry_mem[head1_idx].p_old_rd : '0;

    assign disp_n     = {1'b0, disp_we1} + {1'b0, disp_we2};
    assign ret_n      = {1'b0, ret1} + {1'b0, ret2};
    assign count_next = count + (IDX_W+1)'(disp_n) - (IDX_W+1)'(ret_n);

    // Per-entry decode of this cycle's dispatch, retirement and completion.
    // Several ports naming the same entry simply OR into one completion.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign disp_hit[gi] = (disp_we1 && (tail_idx  == IDX_W'(gi)))
                           || (disp_we2 && (tail1_idx == IDX_W'(gi)));
        assign ret_hit[gi]  = (ret1 && (head_idx  == IDX_W'(gi)))
                           || (ret2 && (head1_idx == IDX_W'(gi)));
        for (genvar gk = 0; gk < NUM_CMP; gk++) begin : g_port
            assign cmp_match[gi][gk] = cmp_valid[gk] && (cmp_idx[gk] == IDX_W'(gi));
        end
        assign cmp_hit[gi] = valid_reg[gi] && (|cmp_match[gi]);
    end

    // Dispatch only targets free entries and retirement only valid ones, so
    // the set/clear terms never collide; a fresh entry always starts not done.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            valid_reg <= '0;
            done_reg  <= '0;
            state_reg <= RUN;
        end else begin
            head_reg  <= head_reg + (IDX_W+1)'(ret_n);
            tail_reg  <= tail_reg + (IDX_W+1)'(disp_n);
            valid_reg <= (valid_reg & ~ret_hit) | disp_hit;
            done_reg  <= (done_reg | cmp_hit) & ~ret_hit & ~disp_hit;
            state_reg <= state_next;
        end
    end

    // Payload needs no reset: an entry is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (disp_we1) begin
            entry_mem[tail_idx] <= '{p_rd: disp_p_rd1, p_old_rd: disp_p_old_rd1};
        end
        if (disp_we2) begin
            entry_mem[tail1_idx] <= '{p_rd: disp_p_rd2, p_old_rd: disp_p_old_rd2};
        end
    end

    // DRAIN ends on the edge that retires the last entry, so finish is high
    // in the cycle right after the final retirement.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            RUN: begin
                if (finish_fetch) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((count_next == '0) && !disp_we1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer: directed scenarios plus a randomized run checked against
// a queue-based model of the reorder buffer (entries in program order, each
// carrying its index, old register and done flag).
// ---------------------------------------------------------------------------
module tb_reorder_buffer;
    import operationList::*;

    localparam int DEPTH = 16;
    localparam int IW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          disp_valid1, disp_valid2;
    logic [5:0]    disp_p_rd1, disp_p_old_rd1, disp_p_rd2, disp_p_old_rd2;
    logic          disp_ready;
    logic [IW-1:0] rob_idx1, rob_idx2;
    logic          cmp_valid [0:2];
    logic [IW-1:0] cmp_idx   [0:2];
    logic          finish_fetch;
    logic [5:0]    free_reg1, free_reg2;
    logic          retire_valid1, retire_valid2;
    logic [IW:0]   count;
    logic          empty, full, finish;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int idx;
        int old;
        bit done;
    } ent_t;
    ent_t q[$];
    int   tail_m;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .disp_valid1(disp_valid1), .disp_valid2(disp_valid2),
        .disp_p_rd1(disp_p_rd1), .disp_p_old_rd1(disp_p_old_rd1),
        .disp_p_rd2(disp_p_rd2), .disp_p_old_rd2(disp_p_old_rd2),
        .disp_ready(disp_ready), .rob_idx1(rob_idx1), .rob_idx2(rob_idx2),
        .cmp_valid(cmp_valid), .cmp_idx(cmp_idx),
        .finish_fetch(finish_fetch),
        .free_reg1(free_reg1), .free_reg2(free_reg2),
        .retire_valid1(retire_valid1), .retire_valid2(retire_valid2),
        .count(count), .empty(empty), .full(full), .finish(finish)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        disp_valid1 = 1'b0; disp_valid2 = 1'b0;
        disp_p_rd1 = '0; disp_p_old_rd1 = '0; disp_p_rd2 = '0; disp_p_old_rd2 = '0;
        finish_fetch = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmp_valid[k] = 1'b0;
            cmp_idx[k]   = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        tick();
        tick();
        rst = 1'b0;
        q.delete();
        tail_m = 0;
    endtask

    task automatic set_disp(input bit v1, input bit v2, input int rd1, input int old1,
                            input int rd2, input int old2);
        disp_valid1 = v1; disp_valid2 = v2;
        disp_p_rd1 = 6'(rd1); disp_p_old_rd1 = 6'(old1);
        disp_p_rd2 = 6'(rd2); disp_p_old_rd2 = 6'(old2);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        set_disp(1, 1, 9, 9, 10, 10);
        tick();
        tick();
        rst = 1'b0;
        drive_idle();
        settle();
        n_checks++; if (disp_ready !== 1'b1) begin n_errors++; $display("FAIL reset_disp_ready: got %b want 1", disp_ready); end
        n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (finish !== 1'b0) begin n_errors++; $display("FAIL reset_finish: got %b want 0", finish); end
        n_checks++; if (free_reg1 !== 6'd0 || free_reg2 !== 6'd0) begin n_errors++; $display("FAIL reset_free_reg: got %0d/%0d want 0/0", free_reg1, free_reg2); end
        n_checks++; if (retire_valid1 !== 1'b0 || retire_valid2 !== 1'b0) begin n_errors++; $display("FAIL reset_retire: got %b/%b want 0/0", retire_valid1, retire_valid2); end
        n_checks++; if (rob_idx1 !== 4'd0 || rob_idx2 !== 4'd1) begin n_errors++; $display("FAIL reset_rob_idx: got %0d/%0d want 0/1", rob_idx1, rob_idx2); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_in_order_retire();
        do_reset();
        set_disp(1, 1, 33, 5, 34, 6);
        settle();
        n_checks++; if (rob_idx1 !== 4'd0 || rob_idx2 !== 4'd1) begin n_errors++; $display("FAIL order_rob_idx: got %0d/%0d want 0/1", rob_idx1, rob_idx2); end
        $display("dispatch idx0 p_rd=33 old=5, idx1 p_rd=34 old=6");
        tick();
        drive_idle();
        cmp_valid[0] = 1'b1; cmp_idx[0] = 4'd1;
        settle();
        n_checks++; if (count !== 5'd2) begin n_errors++; $display("FAIL order_count: got %0d want 2", count); end
        n_checks++; if (retire_valid1 !== 1'b0) begin n_errors++; $display("FAIL order_no_retire_before_head: got %b want 0", retire_valid1); end
        tick();
        cmp_idx[0] = 4'd0;
        settle();
        n_checks++; if (retire_valid1 !== 1'b0 || free_reg1 !== 6'd0) begin n_errors++; $display("FAIL order_same_cycle_cmp: retire=%b free=%0d want 0/0", retire_valid1, free_reg1); end
        tick();
        cmp_valid[0] = 1'b0;
        settle();
        n_checks++; if (retire_valid1 !== 1'b1 || retire_valid2 !== 1'b1) begin n_errors++; $display("FAIL order_retire_both: got %b/%b want 1/1", retire_valid1, retire_valid2); end
        n_checks++; if (free_reg1 !== 6'd5 || free_reg2 !== 6'd6) begin n_errors++; $display("FAIL order_free_regs: got %0d/%0d want 5/6", free_reg1, free_reg2); end
        $display("retire free_reg1=%0d free_reg2=%0d", free_reg1, free_reg2);
        tick();
        settle();
        n_checks++; if (empty !== 1'b1 || retire_valid1 !== 1'b0 || free_reg1 !== 6'd0) begin n_errors++; $display("FAIL order_after_retire: empty=%b retire=%b free=%0d want 1/0/0", empty, retire_valid1, free_reg1); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_full_wrap();
        int nxt;
        int grp;
        do_reset();
        // entry i gets old register i+1
        for (int j = 0; j < 8; j++) begin
            set_disp(1, 1, 32 + 2*j, 2*j + 1, 33 + 2*j, 2*j + 2);
            settle();
            n_checks++; if (rob_idx1 !== 4'(2*j)) begin n_errors++; $display("FAIL fill_rob_idx: got %0d want %0d", rob_idx1, 2*j); end
            tick();
        end
        drive_idle();
        settle();
        n_checks++; if (full !== 1'b1 || count !== 5'd16) begin n_errors++; $display("FAIL fill_full: full=%b count=%0d want 1/16", full, count); end
        n_checks++; if (disp_ready !== 1'b0 || empty !== 1'b0) begin n_errors++; $display("FAIL fill_ready: ready=%b empty=%b want 0/0", disp_ready, empty); end
        tick();
        set_disp(1, 1, 40, 60, 41, 61);
        tick();
        drive_idle();
        settle();
        n_checks++; if (count !== 5'd16 || rob_idx1 !== 4'd0) begin n_errors++; $display("FAIL fill_ignored: count=%0d idx=%0d want 16/0", count, rob_idx1); end
        tick();

        nxt = 0;
        grp = 0;
        for (int c = 0; c < 40 && nxt < 16; c++) begin
            for (int k = 0; k < 3; k++) begin
                cmp_valid[k] = (grp < 6) && (grp*3 + k < 16);
                cmp_idx[k]   = 4'((grp*3 + k) % 16);
            end
            grp++;
            settle();
            if (retire_valid1) begin
                n_checks++; if (free_reg1 !== 6'(nxt + 1)) begin n_errors++; $display("FAIL drain16_order1: got %0d want %0d", free_reg1, nxt + 1); end
                $display("retire free_reg1=%0d", free_reg1);
                nxt++;
                if (retire_valid2) begin
                    n_checks++; if (free_reg2 !== 6'(nxt + 1)) begin n_errors++; $display("FAIL drain16_order2: got %0d want %0d", free_reg2, nxt + 1); end
                    $display("retire free_reg2=%0d", free_reg2);
                    nxt++;
                end
            end
            tick();
        end
        drive_idle();
        n_checks++; if (nxt != 16) begin n_errors++; $display("FAIL drain16_total: got %0d want 16", nxt); end
        settle();
        n_checks++; if (empty !== 1'b1 || rob_idx1 !== 4'd0) begin n_errors++; $display("FAIL drain16_empty: empty=%b idx=%0d want 1/0", empty, rob_idx1); end
        tick();

        for (int j = 0; j < 4; j++) begin
            set_disp(1, 1, 50 + 2*j, 41 + 2*j, 51 + 2*j, 42 + 2*j);
            settle();
            n_checks++; if (rob_idx1 !== 4'(2*j)) begin n_errors++; $display("FAIL wrap_rob_idx: got %0d want %0d", rob_idx1, 2*j); end
            tick();
        end
        drive_idle();
        settle();
        n_checks++; if (rob_idx1 !== 4'd8 || count !== 5'd8) begin n_errors++; $display("FAIL wrap_tail: idx=%0d count=%0d want 8/8", rob_idx1, count); end
        tick();

        nxt = 0;
        for (int c = 0; c < 30 && nxt < 8; c++) begin
            cmp_valid[0] = (c < 8);
            cmp_idx[0]   = 4'((7 - c) & 7);
            settle();
            n_checks++; if (retire_valid1 && c < 8) begin n_errors++; $display("FAIL wrap_early_retire: retired at step %0d before idx 0 done", c); end
            if (retire_valid1) begin
                n_checks++; if (free_reg1 !== 6'(41 + nxt)) begin n_errors++; $display("FAIL wrap_order1: got %0d want %0d", free_reg1, 41 + nxt); end
                nxt++;
                if (retire_valid2) begin
                    n_checks++; if (free_reg2 !== 6'(41 + nxt)) begin n_errors++; $display("FAIL wrap_order2: got %0d want %0d", free_reg2, 41 + nxt); end
                    nxt++;
                end
            end
            tick();
        end
        drive_idle();
        n_checks++; if (nxt != 8) begin n_errors++; $display("FAIL wrap_total: got %0d want 8", nxt); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_registered_count();
        do_reset();
        for (int j = 0; j < 8; j++) begin
            set_disp(1, j < 7, 20 + 2*j, 2*j + 1, 21 + 2*j, 2*j + 2);
            tick();
        end
        drive_idle();
        settle();
        n_checks++; if (count !== 5'd15 || disp_ready !== 1'b0) begin n_errors++; $display("FAIL cnt15_setup: count=%0d ready=%b want 15/0", count, disp_ready); end
        tick();
        cmp_valid[0] = 1'b1; cmp_idx[0] = 4'd0;
        tick();
        drive_idle();
        set_disp(1, 1, 62, 60, 63, 61);
        settle();
        // head retires this cycle, but readiness comes from the registered count of 15
        n_checks++; if (disp_ready !== 1'b0) begin n_errors++; $display("FAIL cnt15_ready: got %b want 0", disp_ready); end
        n_checks++; if (retire_valid1 !== 1'b1 || retire_valid2 !== 1'b0 || free_reg1 !== 6'd1) begin n_errors++; $display("FAIL cnt15_retire: r1=%b r2=%b free=%0d want 1/0/1", retire_valid1, retire_valid2, free_reg1); end
        n_checks++; if (count !== 5'd15) begin n_errors++; $display("FAIL cnt15_count: got %0d want 15", count); end
        tick();
        drive_idle();
        settle();
        n_checks++; if (count !== 5'd14 || rob_idx1 !== 4'd15) begin n_errors++; $display("FAIL cnt15_after: count=%0d idx=%0d want 14/15", count, rob_idx1); end
        tick();
        cmp_valid[0] = 1'b1; cmp_idx[0] = 4'd1;
        tick();
        drive_idle();
        settle();
        n_checks++; if (retire_valid1 !== 1'b1 || free_reg1 !== 6'd2) begin n_errors++; $display("FAIL cnt15_no_overwrite: retire=%b free=%0d want 1/2", retire_valid1, free_reg1); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        bit v1, v2, e_ready, e_r1, e_r2;
        int o1, o2, e_f1, e_f2, sz;
        bit cv [3];
        int ci [3];
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            v1 = ($urandom_range(0, 3) != 0);
            v2 = $urandom_range(0, 1);
            o1 = $urandom_range(1, 63);
            o2 = $urandom_range(1, 63);
            set_disp(v1, v2, $urandom_range(1, 63), o1, $urandom_range(1, 63), o2);
            for (int k = 0; k < 3; k++) begin
                cv[k] = ($urandom_range(0, 1) == 1);
                if (q.size() > 0 && $urandom_range(0, 3) != 0) ci[k] = q[$urandom_range(0, q.size() - 1)].idx;
                else ci[k] = $urandom_range(0, DEPTH - 1);
                cmp_valid[k] = cv[k];
                cmp_idx[k]   = 4'(ci[k]);
            end
            settle();

            sz = q.size();
            e_ready = (DEPTH - sz) >= 2;
            e_r1 = 1'b0; e_r2 = 1'b0; e_f1 = 0; e_f2 = 0;
            if (sz > 0) if (q[0].done) begin e_r1 = 1'b1; e_f1 = q[0].old; end
            if (e_r1 && sz > 1) if (q[1].done) begin e_r2 = 1'b1; e_f2 = q[1].old; end

            n_checks++; if (disp_ready !== e_ready) begin n_errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", cyc, disp_ready, e_ready); end
            n_checks++; if (retire_valid1 !== e_r1 || retire_valid2 !== e_r2) begin n_errors++; $display("FAIL rand_retire cyc %0d: got %b/%b want %b/%b", cyc, retire_valid1, retire_valid2, e_r1, e_r2); end
            n_checks++; if (free_reg1 !== 6'(e_f1) || free_reg2 !== 6'(e_f2)) begin n_errors++; $display("FAIL rand_free cyc %0d: got %0d/%0d want %0d/%0d", cyc, free_reg1, free_reg2, e_f1, e_f2); end
            n_checks++; if (count !== 5'(sz) || empty !== (sz == 0) || full !== (sz == DEPTH)) begin n_errors++; $display("FAIL rand_occupancy cyc %0d: count=%0d empty=%b full=%b want %0d", cyc, count, empty, full, sz); end
            n_checks++; if (rob_idx1 !== 4'(tail_m % DEPTH) || rob_idx2 !== 4'((tail_m + 1) % DEPTH)) begin n_errors++; $display("FAIL rand_rob_idx cyc %0d: got %0d/%0d want %0d", cyc, rob_idx1, rob_idx2, tail_m % DEPTH); end
            if (e_r1) $display("cycle %0d retire %0d entr%s", cyc, e_r2 ? 2 : 1, e_r2 ? "ies" : "y");

            tick();

            for (int k = 0; k < 3; k++)
                if (cv[k])
                    foreach (q[i]) if (q[i].idx == ci[k]) q[i].done = 1'b1;
            if (e_r1) void'(q.pop_front());
            if (e_r2) void'(q.pop_front());
            if (v1 && e_ready) begin
                q.push_back('{idx: tail_m % DEPTH, old: o1, done: 1'b0});
                tail_m++;
                if (v2) begin
                    q.push_back('{idx: tail_m % DEPTH, old: o2, done: 1'b0});
                    tail_m++;
                end
            end
        end
        drive_idle();
    endtask

    // ------------------------------------------------------------------
    task automatic test_drain_finish();
        do_reset();
        set_disp(1, 1, 10, 1, 11, 2);
        tick();
        set_disp(1, 0, 12, 3, 0, 0);
        tick();
        drive_idle();
        finish_fetch = 1'b1;
        settle();
        n_checks++; if (disp_ready !== 1'b1 || finish !== 1'b0) begin n_errors++; $display("FAIL drain_pre: ready=%b finish=%b want 1/0", disp_ready, finish); end
        tick();
        finish_fetch = 1'b0;
        set_disp(1, 1, 13, 50, 14, 51);
        settle();
        n_checks++; if (disp_ready !== 1'b0 || finish !== 1'b0 || count !== 5'd3) begin n_errors++; $display("FAIL drain_ready: ready=%b finish=%b count=%0d want 0/0/3", disp_ready, finish, count); end
        tick();
        drive_idle();
        settle();
        n_checks++; if (count !== 5'd3) begin n_errors++; $display("FAIL drain_dispatch_ignored: count=%0d want 3", count); end
        tick();
        for (int k = 0; k < 3; k++) begin cmp_valid[k] = 1'b1; cmp_idx[k] = 4'(k); end
        tick();
        drive_idle();
        settle();
        n_checks++; if (retire_valid1 !== 1'b1 || retire_valid2 !== 1'b1 || free_reg1 !== 6'd1 || free_reg2 !== 6'd2) begin n_errors++; $display("FAIL drain_retire_a: %b/%b free %0d/%0d want 1/1 1/2", retire_valid1, retire_valid2, free_reg1, free_reg2); end
        n_checks++; if (finish !== 1'b0) begin n_errors++; $display("FAIL drain_finish_early_a: got %b want 0", finish); end
        tick();
        settle();
        n_checks++; if (retire_valid1 !== 1'b1 || retire_valid2 !== 1'b0 || free_reg1 !== 6'd3) begin n_errors++; $display("FAIL drain_retire_b: %b/%b free %0d want 1/0 3", retire_valid1, retire_valid2, free_reg1); end
        n_checks++; if (finish !== 1'b0) begin n_errors++; $display("FAIL drain_finish_early_b: got %b want 0", finish); end
        tick();
        for (int c = 0; c < 4; c++) begin
            settle();
            n_checks++; if (finish !== 1'b1 || disp_ready !== 1'b0 || count !== 5'd0) begin n_errors++; $display("FAIL drain_done step %0d: finish=%b ready=%b count=%0d want 1/0/0", c, finish, disp_ready, count); end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_inflight();
        do_reset();
        settle();
        n_checks++; if (finish !== 1'b0 || disp_ready !== 1'b1) begin n_errors++; $display("FAIL rst_leaves_done: finish=%b ready=%b want 0/1", finish, disp_ready); end
        tick();
        set_disp(1, 1, 20, 1, 21, 2);
        tick();
        set_disp(1, 1, 22, 3, 23, 4);
        tick();
        set_disp(1, 0, 24, 5, 0, 0);
        tick();
        drive_idle();
        cmp_valid[0] = 1'b1; cmp_idx[0] = 4'd1;
        cmp_valid[1] = 1'b1; cmp_idx[1] = 4'd2;
        tick();
        drive_idle();
        settle();
        n_checks++; if (count !== 5'd5 || retire_valid1 !== 1'b0) begin n_errors++; $display("FAIL rst_setup: count=%0d retire=%b want 5/0", count, retire_valid1); end
        tick();
        rst = 1'b1;
        set_disp(1, 1, 30, 30, 31, 31);
        cmp_valid[0] = 1'b1; cmp_idx[0] = 4'd0;
        tick();
        rst = 1'b0;
        drive_idle();
        settle();
        n_checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_errors++; $display("FAIL rst_occupancy: count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
        n_checks++; if (free_reg1 !== 6'd0 || free_reg2 !== 6'd0 || retire_valid1 !== 1'b0 || retire_valid2 !== 1'b0) begin n_errors++; $display("FAIL rst_retire: free %0d/%0d retire %b/%b want 0", free_reg1, free_reg2, retire_valid1, retire_valid2); end
        n_checks++; if (disp_ready !== 1'b1 || finish !== 1'b0 || rob_idx1 !== 4'd0) begin n_errors++; $display("FAIL rst_ready: ready=%b finish=%b idx=%0d want 1/0/0", disp_ready, finish, rob_idx1); end
        tick();
        set_disp(1, 1, 25, 7, 26, 8);
        tick();
        drive_idle();
        cmp_valid[0] = 1'b1; cmp_idx[0] = 4'd0;
        tick();
        drive_idle();
        settle();
        // idx 1 was done before reset; that stale bit must not let lane 2 retire
        n_checks++; if (retire_valid1 !== 1'b1 || free_reg1 !== 6'd7 || retire_valid2 !== 1'b0) begin n_errors++; $display("FAIL rst_stale_done: r1=%b free=%0d r2=%b want 1/7/0", retire_valid1, free_reg1, retire_valid2); end
        tick();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_in_order_retire();
        test_full_wrap();
        test_registered_count();
        test_random();
        test_drain_finish();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
